// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the F-stage PC fetch unit.
//   ADDR_W_DEF   : default PC width
//   RESET_PC_DEF : default PC loaded on reset
//   EXC_VEC_DEF  : default exception entry address
//   npc_src_e    : which source supplies the next fetch PC
//   pend_state_e : redirect-pending state (IDLE / PEND)
package pc_fetch_unit_pkg;

   localparam int unsigned ADDR_W_DEF   = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

   typedef enum logic [2:0] {
      SEQ,
      BR,
      J,
      JR,
      PEND,
      EXC,
      ERET
   } npc_src_e;

   typedef enum logic {
      S_IDLE,
      S_PEND
   } pend_state_e;

endpackage

// File: rtl/pc_fetch_unit_target.sv
// Combinational redirect-target mux for D-stage control transfers.
//   br_taken/j_en/jr_en : redirect requests, priority br > j > jr
//   d_pc                : PC of the instruction in D
//   imm                 : branch offset field (sign-extended, word offset)
//   instr_index         : jump index field
//   jr_target           : forwarded register target
//   target              : selected redirect address
//   redir_v             : any redirect requested
//   src                 : which redirect source was selected (SEQ if none)
module npc_target_calc
   import pc_fetch_unit_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned IMM_W   = 16,
   parameter int unsigned INDEX_W = 26
) (
   input  logic               br_taken,
   input  logic               j_en,
   input  logic               jr_en,
   input  logic [ADDR_W-1:0]  d_pc,
   input  logic [IMM_W-1:0]   imm,
   input  logic [INDEX_W-1:0] instr_index,
   input  logic [ADDR_W-1:0]  jr_target,
   output logic [ADDR_W-1:0]  target,
   output logic               redir_v,
   output npc_src_e           src
);

   // Bits of the PC replaced by a jump; also correct when ADDR_W == INDEX_W+2
   // (the shift then yields zero and the mask becomes all ones).
   localparam logic [ADDR_W-1:0] LOW_MASK = (ADDR_W'(1) << (INDEX_W + 2)) - ADDR_W'(1);

   logic [ADDR_W-1:0] br_off;
   logic [ADDR_W-1:0] br_tgt;
   logic [ADDR_W-1:0] j_tgt;

   always_comb begin
      br_off = {{(ADDR_W - IMM_W){imm[IMM_W-1]}}, imm} << 2;
      br_tgt = d_pc + ADDR_W'(4) + br_off;
      j_tgt  = (d_pc & ~LOW_MASK) | (ADDR_W'(instr_index) << 2);
   end

   always_comb begin
      target  = jr_target;
      src     = SEQ;
      redir_v = br_taken | j_en | jr_en;
      if (br_taken) begin
         target = br_tgt;
         src    = BR;
      end else if (j_en) begin
         target = j_tgt;
         src    = J;
      end else if (jr_en) begin
         target = jr_target;
         src    = JR;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// F-stage PC register and next-PC selection.
//   clk, reset          : clock, synchronous active-high reset
//   stall               : hazard stall, freezes F
//   imem_ready          : instruction for f_pc returned this cycle
//   br_taken/j_en/jr_en : D-stage redirects with their operand fields
//   exc_req/eret_req    : CP0 exception entry / eret, with epc
//   f_pc                : registered fetch PC
//   npc                 : value f_pc takes at the next edge
//   f_adel              : f_pc misaligned
//   pend_valid          : a redirect is latched awaiting the delay-slot fetch
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W   = ADDR_W_DEF,
   parameter int unsigned       IMM_W    = 16,
   parameter int unsigned       INDEX_W  = 26,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
   parameter logic [ADDR_W-1:0] EXC_VEC  = EXC_VEC_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               imem_ready,
   input  logic               br_taken,
   input  logic               j_en,
   input  logic               jr_en,
   input  logic [ADDR_W-1:0]  d_pc,
   input  logic [IMM_W-1:0]   imm,
   input  logic [INDEX_W-1:0] instr_index,
   input  logic [ADDR_W-1:0]  jr_target,
   input  logic               exc_req,
   input  logic               eret_req,
   input  logic [ADDR_W-1:0]  epc,
   output logic [ADDR_W-1:0]  f_pc,
   output logic [ADDR_W-1:0]  npc,
   output logic               f_adel,
   output logic               pend_valid
);

   pend_state_e       state, state_n;
   logic [ADDR_W-1:0] pend_pc, pend_pc_n;
   logic [ADDR_W-1:0] redir_target;
   logic              redir_v;
   npc_src_e          redir_src;
   npc_src_e          src;
   logic              hold;

   npc_target_calc #(
      .ADDR_W  (ADDR_W),
      .IMM_W   (IMM_W),
      .INDEX_W (INDEX_W)
   ) u_target (
      .br_taken    (br_taken),
      .j_en        (j_en),
      .jr_en       (jr_en),
      .d_pc        (d_pc),
      .imm         (imm),
      .instr_index (instr_index),
      .jr_target   (jr_target),
      .target      (redir_target),
      .redir_v     (redir_v),
      .src         (redir_src)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         f_pc    <= RESET_PC;
         state   <= S_IDLE;
         pend_pc <= '0;
      end else begin
         f_pc    <= npc;
         state   <= state_n;
         pend_pc <= pend_pc_n;
      end
   end

   always_comb begin
      hold      = 1'b0;
      src       = SEQ;
      state_n   = state;
      pend_pc_n = pend_pc;
      if (exc_req) begin
         src       = EXC;
         state_n   = S_IDLE;
         pend_pc_n = '0;
      end else if (eret_req) begin
         src       = ERET;
         state_n   = S_IDLE;
         pend_pc_n = '0;
      end else if (stall) begin
         hold = 1'b1;
      end else if (!imem_ready) begin
         // Delay-slot fetch still in flight: remember the newest redirect.
         hold = 1'b1;
         if (redir_v) begin
            state_n   = S_PEND;
            pend_pc_n = redir_target;
         end
      end else if (redir_v) begin
         src       = redir_src;
         state_n   = S_IDLE;
         pend_pc_n = '0;
      end else if (state == S_PEND) begin
         src       = PEND;
         state_n   = S_IDLE;
         pend_pc_n = '0;
      end
   end

   always_comb begin
      npc = f_pc + ADDR_W'(4);
      if (hold) begin
         npc = f_pc;
      end else begin
         case (src)
            BR, J, JR: npc = redir_target;
            PEND:      npc = pend_pc;
            EXC:       npc = EXC_VEC;
            ERET:      npc = epc;
            default:   npc = f_pc + ADDR_W'(4);
         endcase
      end
   end

   assign pend_valid = (state == S_PEND);
   assign f_adel     = |f_pc[1:0];

endmodule
